// File: rtl/back_buffer_clear_arbiter.sv
// Port-B arbiter between the depth comparator and a raster clear sequencer.
// Every buffer switch fills the new back buffer with clear_value before the comparator is granted again.
module back_buffer_clear_arbiter #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int CLEAR_ENABLE = 1,
  parameter int PIXEL_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               switch_buffer,
  input  logic [PIXEL_W-1:0] clear_value,
  input  logic [9:0]         dc_address_x,
  input  logic [9:0]         dc_address_y,
  input  logic [PIXEL_W-1:0] dc_write_data,
  input  logic               dc_write_enable,
  output logic [PIXEL_W-1:0] dc_read_data,
  output logic               dc_grant,
  output logic [9:0]         buf_address_x,
  output logic [9:0]         buf_address_y,
  output logic [PIXEL_W-1:0] buf_write_data,
  output logic               buf_write_enable,
  input  logic [PIXEL_W-1:0] buf_read_data,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [15:0]        dropped_writes
);

  if (H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 1024) begin : g_res_check
    $error("back_buffer_clear_arbiter: H_RES and V_RES must be in 1..1024");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [9:0] X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_RES - 1);
  localparam bit         DO_CLEAR = (CLEAR_ENABLE != 0);

  logic [1:0] state;
  logic [9:0] x;
  logic [9:0] y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (switch_buffer) begin
            state <= DO_CLEAR ? CLEAR : DONE;
            x     <= '0;
            y     <= '0;
          end
        end
        CLEAR: begin
          // A new switch aborts the running sweep and restarts it from the origin.
          if (switch_buffer) begin
            x <= '0;
            y <= '0;
          end else if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
              y     <= '0;
              state <= DONE;
            end else begin
              y <= y + 10'd1;
            end
          end else begin
            x <= x + 10'd1;
          end
        end
        DONE: begin
          x <= '0;
          y <= '0;
          if (switch_buffer) state <= DO_CLEAR ? CLEAR : DONE;
          else               state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped_writes <= '0;
    end else if (dc_write_enable && !dc_grant && (dropped_writes != '1)) begin
      dropped_writes <= dropped_writes + 16'd1;
    end
  end

  always_comb begin
    dc_grant     = (state == IDLE);
    clear_busy   = (state == CLEAR);
    clear_done   = (state == DONE);
    dc_read_data = buf_read_data;
  end

  // The comparator path stays on the bus outside CLEAR; only its strobe is gated.
  always_comb begin
    buf_address_x    = dc_address_x;
    buf_address_y    = dc_address_y;
    buf_write_data   = dc_write_data;
    buf_write_enable = dc_write_enable && dc_grant && !reset;
    if (state == CLEAR) begin
      buf_address_x    = x;
      buf_address_y    = y;
      buf_write_data   = clear_value;
      buf_write_enable = 1'b1;
    end
  end

endmodule

// File: tb/tb_back_buffer_clear_arbiter.sv
// Directed bench for back_buffer_clear_arbiter: a 4x3 clearing instance and a 4x3 instance with clearing disabled.
module tb_back_buffer_clear_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       switch_buffer;
  logic [7:0] clear_value;
  logic [9:0] dc_address_x;
  logic [9:0] dc_address_y;
  logic [7:0] dc_write_data;
  logic       dc_write_enable;
  logic [7:0] buf_read_data;

  logic [7:0]  dc_read_data_a,   dc_read_data_b;
  logic        dc_grant_a,       dc_grant_b;
  logic [9:0]  buf_address_x_a,  buf_address_x_b;
  logic [9:0]  buf_address_y_a,  buf_address_y_b;
  logic [7:0]  buf_write_data_a, buf_write_data_b;
  logic        buf_write_enable_a, buf_write_enable_b;
  logic        clear_busy_a,     clear_busy_b;
  logic        clear_done_a,     clear_done_b;
  logic [15:0] dropped_writes_a, dropped_writes_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  back_buffer_clear_arbiter #(.H_RES(4), .V_RES(3), .CLEAR_ENABLE(1), .PIXEL_W(8)) u_clear (
    .clock(clock), .reset(reset), .switch_buffer(switch_buffer), .clear_value(clear_value),
    .dc_address_x(dc_address_x), .dc_address_y(dc_address_y), .dc_write_data(dc_write_data),
    .dc_write_enable(dc_write_enable), .dc_read_data(dc_read_data_a), .dc_grant(dc_grant_a),
    .buf_address_x(buf_address_x_a), .buf_address_y(buf_address_y_a),
    .buf_write_data(buf_write_data_a), .buf_write_enable(buf_write_enable_a),
    .buf_read_data(buf_read_data), .clear_busy(clear_busy_a), .clear_done(clear_done_a),
    .dropped_writes(dropped_writes_a)
  );

  back_buffer_clear_arbiter #(.H_RES(4), .V_RES(3), .CLEAR_ENABLE(0), .PIXEL_W(8)) u_noclear (
    .clock(clock), .reset(reset), .switch_buffer(switch_buffer), .clear_value(clear_value),
    .dc_address_x(dc_address_x), .dc_address_y(dc_address_y), .dc_write_data(dc_write_data),
    .dc_write_enable(dc_write_enable), .dc_read_data(dc_read_data_b), .dc_grant(dc_grant_b),
    .buf_address_x(buf_address_x_b), .buf_address_y(buf_address_y_b),
    .buf_write_data(buf_write_data_b), .buf_write_enable(buf_write_enable_b),
    .buf_read_data(buf_read_data), .clear_busy(clear_busy_b), .clear_done(clear_done_b),
    .dropped_writes(dropped_writes_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int done_cnt;
  int done_at;

  initial begin
    reset           = 1'b1;
    switch_buffer   = 1'b0;
    clear_value     = 8'h2A;
    dc_address_x    = 10'd3;
    dc_address_y    = 10'd4;
    dc_write_data   = 8'h77;
    dc_write_enable = 1'b1;
    buf_read_data   = 8'h5C;
    #2;
    check("rst_grant", dc_grant_a, 1);
    check("rst_busy", clear_busy_a, 0);
    check("rst_done", clear_done_a, 0);
    check("rst_dropped", dropped_writes_a, 0);
    check("rst_we_forced", buf_write_enable_a, 0);
    check("rst_addr_x_follow", buf_address_x_a, 3);
    check("rst_data_follow", buf_write_data_a, 8'h77);
    tick();
    tick();
    reset = 1'b0;

    // IDLE passthrough
    dc_address_x  = 10'd5;
    dc_address_y  = 10'd7;
    dc_write_data = 8'h11;
    #1;
    check("idle_x", buf_address_x_a, 5);
    check("idle_y", buf_address_y_a, 7);
    check("idle_data", buf_write_data_a, 8'h11);
    check("idle_we", buf_write_enable_a, 1);
    check("idle_rd", dc_read_data_a, 8'h5C);
    buf_read_data = 8'hA5;
    #1;
    check("idle_rd_track", dc_read_data_a, 8'hA5);
    tick();
    check("idle_dropped", dropped_writes_a, 0);

    // Full sweep with comparator writes held on throughout
    switch_buffer = 1'b1;
    #1;
    check("sw_cycle_grant", dc_grant_a, 1);
    tick();
    switch_buffer = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      #1;
      check("sweep_we", buf_write_enable_a, 1);
      check("sweep_x", buf_address_x_a, i % 4);
      check("sweep_y", buf_address_y_a, i / 4);
      check("sweep_data", buf_write_data_a, 8'h2A);
      check("sweep_grant", dc_grant_a, 0);
      check("sweep_busy", clear_busy_a, 1);
      check("sweep_done", clear_done_a, 0);
      check("sweep_rd", dc_read_data_a, 8'hA5);
    end
    tick();
    #1;
    check("done_pulse", clear_done_a, 1);
    check("done_busy", clear_busy_a, 0);
    check("done_grant", dc_grant_a, 0);
    check("done_we", buf_write_enable_a, 0);
    tick();
    #1;
    check("after_done", clear_done_a, 0);
    check("after_grant", dc_grant_a, 1);
    check("after_we", buf_write_enable_a, 1);
    check("dropped_13", dropped_writes_a, 13);
    dc_write_enable = 1'b0;

    // Restart mid-sweep
    tick();
    switch_buffer = 1'b1;
    tick();
    switch_buffer = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
    end
    #1;
    check("pre_restart_x", buf_address_x_a, 1);
    check("pre_restart_y", buf_address_y_a, 1);
    switch_buffer = 1'b1;
    tick();
    switch_buffer = 1'b0;
    #1;
    check("restart_x", buf_address_x_a, 0);
    check("restart_y", buf_address_y_a, 0);
    check("restart_busy", clear_busy_a, 1);
    done_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      #1;
      if (clear_done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    check("restart_done_at", done_at, 12);
    check("restart_done_cnt", done_cnt, 1);

    // Reset in the middle of a sweep
    tick();
    dc_write_enable = 1'b1;
    switch_buffer   = 1'b1;
    tick();
    switch_buffer = 1'b0;
    for (int c = 2; c <= 4; c++) tick();
    #1;
    check("pre_rst_busy", clear_busy_a, 1);
    check("pre_rst_x", buf_address_x_a, 3);
    reset = 1'b1;
    #1;
    check("midrst_grant", dc_grant_a, 1);
    check("midrst_busy", clear_busy_a, 0);
    check("midrst_done", clear_done_a, 0);
    check("midrst_we", buf_write_enable_a, 0);
    check("midrst_dropped", dropped_writes_a, 0);
    check("midrst_x", buf_address_x_a, 5);
    tick();
    reset           = 1'b0;
    dc_write_enable = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      #1;
      if (clear_done_a) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_grant_after", dc_grant_a, 1);

    // Clearing disabled: done follows the switch directly
    dc_write_enable = 1'b1;
    tick();
    switch_buffer = 1'b1;
    #1;
    check("nc_sw_grant", dc_grant_b, 1);
    check("nc_sw_we", buf_write_enable_b, 1);
    tick();
    switch_buffer = 1'b0;
    #1;
    check("nc_done", clear_done_b, 1);
    check("nc_done_grant", dc_grant_b, 0);
    check("nc_done_busy", clear_busy_b, 0);
    check("nc_done_we", buf_write_enable_b, 0);
    tick();
    #1;
    check("nc_after_done", clear_done_b, 0);
    check("nc_after_grant", dc_grant_b, 1);
    check("nc_after_we", buf_write_enable_b, 1);
    check("nc_dropped", dropped_writes_b, 1);

    // Saturation: switch held keeps both instances ungranted
    switch_buffer = 1'b1;
    for (int k = 0; k < 65540; k++) tick();
    #1;
    check("sat_a", dropped_writes_a, 16'hFFFF);
    check("sat_b", dropped_writes_b, 16'hFFFF);
    check("sat_busy", clear_busy_a, 1);
    switch_buffer = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    #1;
    check("sat_hold", dropped_writes_a, 16'hFFFF);
    reset = 1'b1;
    #1;
    check("sat_reset", dropped_writes_a, 0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/back_buffer_clear_arbiter.md
Name: back_buffer_clear_arbiter

Overview:
- Owns display-buffer port B: shares it between the depth comparator (normal writes) and a built-in clear sequencer.
- On every buffer switch, fills the new back buffer with a background pixel before the comparator may touch it.
- Sits between depth_comparator and display_buffer_mux port B.
- Gives task_dispatcher a clear_done pulse, so rasterization of the next frame is gated on a clean buffer.

Parameters:
- H_RES, 640: pixels per line swept by the clear; x range 0..H_RES-1.
- V_RES, 480: lines swept by the clear; y range 0..V_RES-1.
- CLEAR_ENABLE, 1: 0 skips the sweep; switch still yields clear_done one cycle later.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- switch_buffer  in  1  one-cycle pulse from dispatcher on buffer swap; starts a clear.
- clear_value  in  pixel_t  background pixel written during clear; sampled every clear cycle.
- dc_address_x  in  10  comparator x address.
- dc_address_y  in  10  comparator y address.
- dc_write_data  in  pixel_t  comparator write data.
- dc_write_enable  in  1  comparator write strobe.
- dc_read_data  out  pixel_t  port-B read data returned to the comparator.
- dc_grant  out  1  comparator owns port B this cycle.
- buf_address_x  out  10  port-B x address to the mux.
- buf_address_y  out  10  port-B y address to the mux.
- buf_write_data  out  pixel_t  port-B write data.
- buf_write_enable  out  1  port-B write strobe.
- buf_read_data  in  pixel_t  port-B read data from the mux.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse when the sweep finishes.
- dropped_writes  out  16  saturating count of comparator writes issued without grant.

Behaviour:
- Reset (async, active-high): state IDLE, counters x=y=0, dropped_writes=0, clear_busy=0, clear_done=0, dc_grant=1.
- While reset is asserted, buf_* follow the comparator path with buf_write_enable forced 0.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - dc_grant=1; buf_address_x/y, buf_write_data and buf_write_enable are combinational passthroughs of the dc_* inputs.
  - On switch_buffer with CLEAR_ENABLE=1: go to CLEAR with x=y=0.
  - On switch_buffer with CLEAR_ENABLE=0: go to DONE.
- CLEAR:
  - dc_grant=0, clear_busy=1, buf_write_enable=1, buf_address=(x,y), buf_write_data=clear_value.
  - One pixel per cycle, raster order: x increments; at x=H_RES-1, x wraps to 0 and y increments.
  - The cycle writing (H_RES-1, V_RES-1) is the last; next state DONE.
  - Sweep length is exactly H_RES*V_RES cycles.
- DONE:
  - clear_done=1 and dc_grant=0 for exactly one cycle, clear_busy=0, buf_write_enable=0; then IDLE.
  - dc_grant rises on the cycle after clear_done.
- Clear has absolute priority; there is no interleaving with comparator traffic.
- dc_read_data = buf_read_data in every state, combinationally. The comparator ignores it when dc_grant=0.
- Dropped writes:
  - dc_write_enable=1 while dc_grant=0 is never forwarded; dropped_writes increments by 1.
  - dropped_writes saturates at 16'hFFFF and is cleared only by reset.
- switch_buffer during CLEAR: the sweep restarts at (0,0) on the next cycle; no clear_done for the aborted sweep.
- switch_buffer during DONE: clear_done still pulses; the next state is CLEAR at (0,0) instead of IDLE.
- Reset mid-sweep: immediate return to IDLE, no clear_done.
- Counters are 10 bits wide. H_RES and V_RES must each be ≤1024, enforced by an elaboration-time assertion.

Test Plan:
- H_RES=4, V_RES=3; pulse switch_buffer in IDLE with clear_value=8'h2A:
  - Writes occur on 12 consecutive cycles at (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), all data 8'h2A.
  - clear_done pulses once on cycle 13; dc_grant=1 from cycle 14.
- In IDLE, drive dc address (5,7), data 8'h11, dc_write_enable=1:
  - buf_* match in the same cycle; dropped_writes stays 0; dc_read_data tracks buf_read_data.
- Hold dc_write_enable=1 for an entire 12-cycle sweep:
  - No comparator write reaches buf_*; dropped_writes=13, covering 12 CLEAR cycles plus the DONE cycle.
- Re-pulse switch_buffer at sweep cycle 6:
  - Address returns to (0,0) the next cycle; clear_done appears 12 cycles after the re-pulse, exactly once in total.
- Assert reset at sweep cycle 4:
  - Outputs immediately take reset values; clear_done never pulses; dc_grant=1.
- CLEAR_ENABLE=0, pulse switch_buffer:
  - clear_done pulses the next cycle; buf_write_enable stays 0; dc_grant=0 for that single cycle only.
